// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the main-memory arbiter
package mem_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH     = 16;
    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int DEF_MEM_LATENCY    = 4;
    localparam int DATA_W             = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // On a tie the port that did not win last time gets the memory.
    function automatic grant_e pick_grant(input logic i_req, input logic d_req,
                                          input grant_e last_grant);
        if (i_req && d_req) begin
            return (last_grant == GNT_I) ? GNT_D : GNT_I;
        end
        return d_req ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-port and memory-port signal bundle for mem_arbiter
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_fill_valid;
    logic [IDX_W-1:0]      i_fill_idx;
    logic [DATA_W-1:0]     i_fill_data;
    logic                  i_done;

    logic                  d_req;
    logic                  d_wr;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_fill_valid;
    logic [IDX_W-1:0]      d_fill_idx;
    logic [DATA_W-1:0]     d_fill_data;
    logic                  d_done;

    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_data_in;
    logic [DATA_W-1:0]     mem_data_out;
    logic                  mem_data_valid;

    modport slave (
        input  i_req, i_addr,
        output i_fill_valid, i_fill_idx, i_fill_data, i_done,
        input  d_req, d_wr, d_addr, d_wdata,
        output d_fill_valid, d_fill_idx, d_fill_data, d_done,
        output mem_enable, mem_wr, mem_addr, mem_data_in,
        input  mem_data_out, mem_data_valid
    );

    modport master (
        output i_req, i_addr,
        input  i_fill_valid, i_fill_idx, i_fill_data, i_done,
        output d_req, d_wr, d_addr, d_wdata,
        input  d_fill_valid, d_fill_idx, d_fill_data, d_done,
        input  mem_enable, mem_wr, mem_addr, mem_data_in,
        output mem_data_out, mem_data_valid
    );

endinterface

// File: rtl/mem_arbiter_beat_ctr.sv
// rtl/mem_arbiter_beat_ctr.sv - paired issue/return word counters for one line fill
module mem_arbiter_beat_ctr #(
    parameter int WORDS_PER_LINE = 8,
    parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             issue_en,
    input  logic             ret_en,
    output logic [IDX_W-1:0] issue_idx,
    output logic [IDX_W-1:0] ret_idx,
    output logic             issue_last,
    output logic             return_last
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    logic [IDX_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        if (start) begin
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
        end else begin
            if (issue_en) issue_cnt_d = issue_cnt_q + IDX_W'(1);
            if (ret_en)   ret_cnt_d   = ret_cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign issue_idx   = issue_cnt_q;
    assign ret_idx     = ret_cnt_q;
    assign issue_last  = (issue_cnt_q == LAST_IDX);
    assign return_last = (ret_cnt_q == LAST_IDX);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one pipelined main memory between I-cache fills and D-cache fills/writes
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int MEM_LATENCY    = DEF_MEM_LATENCY
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    arb_state_e            state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  issuing_q, issuing_d;
    logic [MEM_LATENCY-1:0] rd_pend_q, rd_pend_d;

    grant_e           pick;
    logic             start;
    logic             in_fill;
    logic             rd_fire;
    logic             ret_en;
    logic             fill_done;
    logic [IDX_W-1:0] issue_idx, ret_idx;
    logic             issue_last, return_last;

    assign in_fill   = (state_q == I_FILL) || (state_q == D_FILL);
    assign rd_fire   = in_fill && issuing_q;
    // Only a return slot owed to one of our own reads is accepted, so stray valids are dropped.
    assign ret_en    = in_fill && bus.mem_data_valid && rd_pend_q[MEM_LATENCY-1];
    assign fill_done = ret_en && return_last;
    assign rd_pend_d = MEM_LATENCY'({rd_pend_q, rd_fire});

    mem_arbiter_beat_ctr #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .IDX_W          (IDX_W)
    ) u_beat_ctr (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .issue_en    (rd_fire),
        .ret_en      (ret_en),
        .issue_idx   (issue_idx),
        .ret_idx     (ret_idx),
        .issue_last  (issue_last),
        .return_last (return_last)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        issuing_d    = issuing_q;
        start        = 1'b0;
        pick         = pick_grant(bus.i_req, bus.d_req, last_grant_q);

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    last_grant_d = pick;
                    if (pick == GNT_I) begin
                        addr_d  = bus.i_addr;
                        state_d = I_FILL;
                        start   = 1'b1;
                    end else begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        if (bus.d_wr) begin
                            state_d = D_WRITE;
                        end else begin
                            state_d = D_FILL;
                            start   = 1'b1;
                        end
                    end
                end
            end
            I_FILL, D_FILL: begin
                if (fill_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            issuing_d = 1'b1;
        end else if (rd_fire && issue_last) begin
            issuing_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            issuing_q    <= 1'b0;
            rd_pend_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            issuing_q    <= issuing_d;
            rd_pend_q    <= rd_pend_d;
        end
    end

    always_comb begin
        bus.mem_enable   = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_data_in  = '0;
        bus.i_fill_valid = 1'b0;
        bus.i_fill_idx   = '0;
        bus.i_fill_data  = '0;
        bus.i_done       = 1'b0;
        bus.d_fill_valid = 1'b0;
        bus.d_fill_idx   = '0;
        bus.d_fill_data  = '0;
        bus.d_done       = 1'b0;

        if (rd_fire) begin
            bus.mem_enable = 1'b1;
            bus.mem_addr   = {addr_q[ADDR_WIDTH-1:IDX_W+1], issue_idx, 1'b0};
        end

        if (state_q == D_WRITE) begin
            bus.mem_enable  = 1'b1;
            bus.mem_wr      = 1'b1;
            bus.mem_addr    = addr_q & ~ADDR_WIDTH'(1);
            bus.mem_data_in = wdata_q;
            bus.d_done      = 1'b1;
        end

        if (ret_en && (state_q == I_FILL)) begin
            bus.i_fill_valid = 1'b1;
            bus.i_fill_idx   = ret_idx;
            bus.i_fill_data  = bus.mem_data_out;
            bus.i_done       = return_last;
        end

        if (ret_en && (state_q == D_FILL)) begin
            bus.d_fill_valid = 1'b1;
            bus.d_fill_idx   = ret_idx;
            bus.d_fill_data  = bus.mem_data_out;
            bus.d_done       = return_last;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-timeline model
module tb_mem_arbiter;
    localparam int AW   = 16;
    localparam int WPL  = 8;
    localparam int LAT  = 4;
    localparam int RING = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .WORDS_PER_LINE (WPL),
        .MEM_LATENCY    (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    // Main memory: single-cycle write, LAT-deep read pipeline cleared by rst.
    logic [15:0] mem_arr [32768];
    bit          wr_seen [32768];
    logic [LAT-1:0] pv;
    logic [15:0]    pd [LAT];

    always @(posedge clk) begin
        if (bus.mem_enable && bus.mem_wr) begin
            mem_arr[bus.mem_addr[15:1]] <= bus.mem_data_in;
            wr_seen[bus.mem_addr[15:1]] <= 1'b1;
        end
        pv <= rst ? '0 : {pv[LAT-2:0], bus.mem_enable & ~bus.mem_wr};
        pd[0] <= wr_seen[bus.mem_addr[15:1]] ? mem_arr[bus.mem_addr[15:1]]
                                              : init_word(int'(bus.mem_addr[15:1]));
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end

    assign bus.mem_data_valid = pv[LAT-1];
    assign bus.mem_data_out   = pd[LAT-1];

    // Reference model state: expected outputs per cycle, memory image, arbitration history.
    logic [33:0] exp_mem [RING];
    logic [20:0] exp_i   [RING];
    logic [20:0] exp_d   [RING];
    logic [15:0] img [int];
    int   free_at   = 0;
    int   i_done_at = -100;
    int   d_done_at = -100;
    bit   last_d    = 1'b0;

    bit          i_want = 1'b0;
    bit          d_want = 1'b0;
    bit          auto_mode = 1'b0;
    bit          rst_v = 1'b1;
    logic [15:0] i_addr_v = '0;
    logic [15:0] d_addr_v = '0;
    logic [15:0] d_wdata_v = '0;
    logic        d_wr_v = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] img_read(input int w);
        return img.exists(w) ? img[w] : init_word(w);
    endfunction

    task automatic model_cycle(input logic r);
        logic        take_d;
        logic [15:0] wa;
        int          base;
        int          a;
        logic [20:0] ent;
        if (r) begin
            for (int j = 0; j < RING; j++) begin
                exp_mem[j] = '0;
                exp_i[j]   = '0;
                exp_d[j]   = '0;
            end
            free_at   = cyc + 1;
            last_d    = 1'b0;
            i_want    = 1'b0;
            d_want    = 1'b0;
            i_done_at = -100;
            d_done_at = -100;
            return;
        end
        if (cyc < free_at) return;
        if (!(bus.i_req || bus.d_req)) return;
        take_d = bus.d_req && (!bus.i_req || !last_d);
        last_d = take_d;
        if (take_d && bus.d_wr) begin
            wa = bus.d_addr & 16'hFFFE;
            exp_mem[(cyc + 1) % RING] = {2'b11, wa, bus.d_wdata};
            exp_d[(cyc + 1) % RING]   = {1'b0, 3'd0, 16'd0, 1'b1};
            img[int'(wa) / 2] = bus.d_wdata;
            free_at   = cyc + 2;
            d_done_at = cyc + 1;
        end else begin
            base = take_d ? int'(bus.d_addr) : int'(bus.i_addr);
            base = base - (base % (2 * WPL));
            for (int k = 0; k < WPL; k++) begin
                a = base + 2 * k;
                exp_mem[(cyc + 1 + k) % RING] = {2'b10, 16'(a), 16'h0000};
                ent = {1'b1, 3'(k), img_read(a / 2), (k == WPL - 1)};
                if (take_d) exp_d[(cyc + 1 + LAT + k) % RING] = ent;
                else        exp_i[(cyc + 1 + LAT + k) % RING] = ent;
            end
            free_at = cyc + 1 + WPL + LAT;
            if (take_d) d_done_at = cyc + WPL + LAT;
            else        i_done_at = cyc + WPL + LAT;
        end
    endtask

    task automatic step();
        logic rst_now;
        @(negedge clk);
        cyc++;
        check_eq("mem_port", 64'({bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in}),
                 64'(exp_mem[cyc % RING]));
        check_eq("i_port", 64'({bus.i_fill_valid, bus.i_fill_idx, bus.i_fill_data, bus.i_done}),
                 64'(exp_i[cyc % RING]));
        check_eq("d_port", 64'({bus.d_fill_valid, bus.d_fill_idx, bus.d_fill_data, bus.d_done}),
                 64'(exp_d[cyc % RING]));
        exp_mem[cyc % RING] = '0;
        exp_i[cyc % RING]   = '0;
        exp_d[cyc % RING]   = '0;

        if (cyc == i_done_at + 1) i_want = 1'b0;
        if (cyc == d_done_at + 1) d_want = 1'b0;
        rst_now = rst_v;
        if (auto_mode) begin
            i_addr_v  = 16'h0A00 | 16'($urandom_range(0, 511));
            d_addr_v  = 16'h0A00 | 16'($urandom_range(0, 511));
            d_wdata_v = 16'($urandom);
            d_wr_v    = ($urandom_range(0, 2) == 0);
            if (!i_want && cyc != i_done_at + 1 && $urandom_range(0, 3) == 0) i_want = 1'b1;
            if (!d_want && cyc != d_done_at + 1 && $urandom_range(0, 3) == 0) d_want = 1'b1;
            if ($urandom_range(0, 199) == 0) rst_now = 1'b1;
        end

        rst         = rst_now;
        bus.i_req   = i_want;
        bus.i_addr  = i_addr_v;
        bus.d_req   = d_want;
        bus.d_wr    = d_wr_v;
        bus.d_addr  = d_addr_v;
        bus.d_wdata = d_wdata_v;
        model_cycle(rst_now);
    endtask

    initial begin
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        for (int j = 0; j < RING; j++) begin
            exp_mem[j] = '0;
            exp_i[j]   = '0;
            exp_d[j]   = '0;
        end

        repeat (3) step();
        rst_v = 1'b0;
        repeat (2) step();

        // Tie from reset: D first, then I; a second tie goes to D again.
        i_want = 1'b1; d_want = 1'b1; d_wr_v = 1'b0;
        i_addr_v = 16'h0126; d_addr_v = 16'h0A00;
        repeat (30) step();
        i_want = 1'b1; d_want = 1'b1;
        repeat (30) step();

        // I-only fill of line 0x0120.
        i_want = 1'b1; i_addr_v = 16'h0126;
        repeat (16) step();

        // Word write, then fill of the same line picks it up at idx 2.
        d_want = 1'b1; d_wr_v = 1'b1; d_addr_v = 16'h0A04; d_wdata_v = 16'hBEEF;
        repeat (4) step();
        d_want = 1'b1; d_wr_v = 1'b0; d_addr_v = 16'h0A00;
        repeat (16) step();

        // I request and D address change arrive while a D fill is running.
        d_want = 1'b1; d_wr_v = 1'b0; d_addr_v = 16'h0A30;
        step();
        step();
        step();
        i_want = 1'b1; i_addr_v = 16'h0150;
        step();
        d_addr_v = 16'h0B00;
        step();
        repeat (30) step();

        // Reset six cycles into a fill, then a fresh fill.
        i_want = 1'b1; i_addr_v = 16'h0A40;
        step();
        repeat (5) step();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        repeat (12) step();
        i_want = 1'b1;
        repeat (16) step();

        auto_mode = 1'b1;
        repeat (3000) step();
        auto_mode = 1'b0;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single shared multicycle main memory (single-cycle write, 4-cycle pipelined read with `data_valid`) between the instruction-cache miss handler (I-port, fills only) and the data-cache miss handler (D-port, fills and write-through word writes). It sequences each 8-word line fill as 8 back-to-back reads, steers returned words to the granted port with a word index, and holds the grant for the whole transaction. It sits between both cache controllers and the memory instance.

## Interface
- `ADDR_WIDTH`, 16, byte-address width
- `WORDS_PER_LINE`, 8, 16-bit words per cache line (power of 2)
- `MEM_LATENCY`, 4, cycles from read issue to `mem_data_valid`
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `i_req` in 1: I-port fill request, held until `i_done`
- `i_addr` in ADDR_WIDTH: I-port miss address (line base derived)
- `i_fill_valid` out 1: returned word valid for I-port
- `i_fill_idx` out log2(WORDS_PER_LINE): word index of `i_fill_data`
- `i_fill_data` out 16: returned word
- `i_done` out 1: one-cycle pulse, I transaction complete
- `d_req` in 1: D-port request, held until `d_done`
- `d_wr` in 1: 1 = single-word write, 0 = line fill
- `d_addr` in ADDR_WIDTH: D-port address
- `d_wdata` in 16: write data
- `d_fill_valid`, `d_fill_idx`, `d_fill_data`, `d_done` out: as I-port
- `mem_enable` out 1, `mem_wr` out 1, `mem_addr` out ADDR_WIDTH, `mem_data_in` out 16: to memory
- `mem_data_out` in 16, `mem_data_valid` in 1: from memory

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE. Reset → IDLE.
- IDLE: requests sampled. Only one active → grant it. Both active → round-robin: grant the port not granted last; `last_grant` resets to I, so D wins the first tie. Next state is D_WRITE if D is granted with `d_wr=1`, D_FILL if `d_wr=0`, I_FILL for I.
- Address inputs, `d_wr` and `d_wdata` are sampled only in the IDLE grant cycle and registered. Later input changes are ignored until done.
- FILL: issue counter k = 0..WORDS_PER_LINE-1, one read per cycle. `mem_enable=1`, `mem_wr=0`, `mem_addr = {line_base, k, 1'b0}`, where `line_base = addr[ADDR_WIDTH-1:log2(WORDS_PER_LINE)+1]`. After the last issue, `mem_enable=0`.
- Return counter increments on each `mem_data_valid`. Granted port gets `*_fill_valid = mem_data_valid`, `*_fill_data = mem_data_out`, `*_fill_idx` = return count. These are combinational from the memory outputs, gated by grant.
- `*_done` pulses together with the last returned word. The next state is IDLE.
- D_WRITE: one cycle with `mem_enable=1`, `mem_wr=1`, `mem_addr=d_addr` and `mem_data_in=d_wdata`. `d_done=1` in the same cycle; the next state is IDLE.
- Non-granted port outputs are held at 0. `mem_data_valid` outside FILL is ignored.
- The requester drops `req` in the cycle after `done`. The cycle after `done` is IDLE and samples requests afresh.
- Address bit 0 is forced to 0 on `mem_addr`.

## Timing
- Fill granted in cycle T (IDLE):
  - Issues occur in T+1..T+8.
  - Data is valid in T+5..T+12.
  - `done` is asserted in T+12.
  - IDLE in T+13.
  - Total occupancy is 13 cycles incl. grant cycle; the generic form is 1 + WORDS_PER_LINE + MEM_LATENCY.
- Write granted in T: memory write and `d_done` in T+1; IDLE in T+2.
- Reset values: all outputs 0, state IDLE, counters 0, `last_grant`=I.
- `rst` mid-transaction: the block returns to IDLE next cycle with no `done` pulse. The memory pipeline also clears on the same `rst`, so no stale `data_valid` arrives. Requesters must re-request.
- Simultaneous `done` and new request from the other port: the new request is sampled in the following IDLE cycle, not the done cycle.

## Structure
- Package `mem_arbiter_pkg` holds:
  - state enum (IDLE, I_FILL, D_FILL, D_WRITE)
  - grant encoding (GNT_I, GNT_D)
  - default constants WORDS_PER_LINE=8, MEM_LATENCY=4
- One sub-module, `mem_arbiter_beat_ctr`: paired issue/return counters with `start`, `issue_last` and `return_last` flags. The top level holds the FSM, grant register and output steering.

## Test plan
- I-only fill at `i_addr=16'h0126` → reads at 0x0120,0x0122,…,0x012E in T+1..T+8. `i_fill_valid` in T+5..T+12 with idx 0..7 matching image words. `i_done` in T+12.
- D write `d_addr=16'h0A04`, `d_wdata=16'hBEEF` → `mem_wr=1` at T+1 with `d_done`. A subsequent D fill of line 0x0A00 returns 0xBEEF at idx 2.
- `i_req` and `d_req` (fill) asserted together from reset → D granted first, I granted in the IDLE cycle after `d_done`. Repeat the tie → D granted next: alternation.
- D fill in progress; `i_req` raised at T+3 and `d_addr` changed at T+4 → D addresses unchanged, no I outputs until D done, then I fill runs.
- `rst` asserted at T+6 of a fill → all outputs 0 next cycle, no `done`, no stray `fill_valid` afterward. A new `i_req` after reset completes normally.
